level_sequencer: RTL and testbench
==================================

# level_sequencer

Game-level controller that drives the shared biker control interface: it issues the start-of-level, start-movement and end-of-level pulses, owns the per-biker enable mask, consumes per-biker hit events and the player-hit event, and tracks level and lives. Sits in the top-level game logic beside the biker array; every biker FSM receives its outputs, with `level` and one bit of `bikerEnabled` per biker.

## Interface
- `NUM_BIKERS`, 4: number of enemy bikers, 1..8.
- `COUNTDOWN_TENTHS`, 30: tenths of a second from level load to movement start, 1..255.
- `CLEAR_DELAY_TENTHS`, 10: tenths of a second from last biker hit to `endLevel`, 1..255. Must be at least the biker flash time.
- `MAX_LEVEL`, 9: final level, 1..15.
- `LIVES`, 3: initial lives, 1..3.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous reset, active-high.
- `startGame` in 1: pulse; honoured only in IDLE or GAME_OVER.
- `oneTensSec` in 1: one-cycle tick every 0.1 s.
- `bikerHit` in NUM_BIKERS: per-biker hit pulse.
- `playerHit` in 1: player-death pulse.
- `startOfLevel` out 1: one-cycle pulse.
- `startMovement` out 1: one-cycle pulse.
- `endLevel` out 1: one-cycle pulse.
- `bikerEnabled` out NUM_BIKERS: enable mask, one bit per biker.
- `level` out 4: current level, 1-based.
- `lives` out 2: remaining lives.
- `gameOver` out 1: high in GAME_OVER.
- `gameWon` out 1: high in GAME_OVER when all levels were cleared.

## Operation
- States: IDLE, LOAD, COUNTDOWN, GO, PLAY, CLEAR_DELAY, END, GAME_OVER.
- The pulse outputs are pure state decodes: `startOfLevel` = LOAD, `startMovement` = GO, `endLevel` = END, `gameOver` = GAME_OVER.
- IDLE/GAME_OVER + `startGame`: set level=1, lives=LIVES, `gameWon`=0, then go to LOAD.
- Entering LOAD: `bikerEnabled` = low min(level, NUM_BIKERS) bits set, rest 0. The mask is valid in the same cycle `startOfLevel` is high.
- LOAD goes to COUNTDOWN and loads the timer with COUNTDOWN_TENTHS.
- COUNTDOWN goes to GO when the timer reaches its terminal count; GO goes to PLAY.
- PLAY:
  - `bikerHit[i]` clears `bikerEnabled[i]`.
  - A hit on a bit that is already 0 is ignored.
  - When the mask becomes 0, go to CLEAR_DELAY (timer = CLEAR_DELAY_TENTHS) with cause=clear.
  - `playerHit` goes to END with cause=death.
- CLEAR_DELAY goes to END at terminal count. `playerHit` during CLEAR_DELAY is ignored.
- END clears `bikerEnabled` to 0.
  - cause=death: lives−1; if the result is 0, go to GAME_OVER; otherwise go to LOAD at the same level.
  - cause=clear: if level==MAX_LEVEL, go to GAME_OVER with `gameWon`=1; otherwise level+1, then LOAD.
- Same-cycle events: `playerHit` with a hit that clears the last biker resolves as death. Multiple `bikerHit` bits in one cycle all clear.
- Hits outside PLAY (and `playerHit` outside PLAY) are ignored. `startGame` outside IDLE/GAME_OVER is ignored.

## Timing
- Reset values: state=IDLE, level=1, lives=LIVES, `bikerEnabled`=0, `gameWon`=0, all pulses 0, timer cleared.
- Reset mid-level returns to IDLE immediately with no `endLevel` pulse.
- All outputs are registered; state and mask update on the `clk` edge after the causing input.
- Latencies:
  - `startGame` to `startOfLevel`: 1 cycle.
  - `startOfLevel` to `startMovement`: COUNTDOWN_TENTHS ticks plus 2 cycles.
  - Last hit to `endLevel`: CLEAR_DELAY_TENTHS ticks plus 1 cycle.
  - `playerHit` to `endLevel`: 1 cycle.
  - `endLevel` to next `startOfLevel`: 1 cycle.
- Timer counts only on `oneTensSec`. Its terminal count is the cycle in which the loaded number of ticks has elapsed.
- Widths: level is a 4-bit unsigned value and never exceeds MAX_LEVEL. lives is 2-bit and never decrements below 0.

## Configuration
- `LEVEL_SEQ_ENDLESS_EN`:
  - Defined: clearing MAX_LEVEL reloads MAX_LEVEL (level saturates), `gameWon` stays 0, and play continues until lives reach 0.
  - Undefined: clearing MAX_LEVEL ends in GAME_OVER with `gameWon`=1.

## Structure
- Shared package `game_pkg`:
  - State enum `level_state_t`.
  - End-cause enum.
  - Default constants for MAX_LEVEL, LIVES and NUM_BIKERS.
- One sub-module, `tenths_countdown`: 8-bit loadable down-counter.
  - Inputs: `clk`, `reset`, `load`, `value`, `tick`.
  - Output: `tc`.
  - Instantiated once and shared by COUNTDOWN and CLEAR_DELAY.

## Test plan
- Default parameters, `startGame` pulse:
  - `startOfLevel` 1 cycle later with `bikerEnabled`=4'b0001 and level=1.
  - `startMovement` after 30 ticks.
- Level 3, PLAY, hit bikers 0, 1, 2 on separate cycles:
  - Mask steps 0111 → 0110 → 0100 → 0000.
  - `endLevel` 10 ticks later.
  - level=4, next `startOfLevel` shows mask 1111.
- PLAY with lives=1, `playerHit`: `endLevel` next cycle, lives=0, `gameOver`=1, `gameWon`=0.
- `playerHit` and the last `bikerHit` in the same cycle: resolves as death, lives 3→2, level unchanged, reload.
- Level=9, clear all bikers:
  - Macro undefined: `gameOver`=1 and `gameWon`=1.
  - Macro defined: level stays 9 and `startOfLevel` pulses again.
- `reset` asserted mid-COUNTDOWN:
  - All outputs return to reset values at once.
  - `bikerHit` and `startMovement` activity is absent until the next `startGame`.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: level sequencer states, end causes and default game constants
package game_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COUNTDOWN, S_GO, S_PLAY, S_CLEAR_DELAY, S_END, S_GAME_OVER
  } level_state_t;
  typedef enum logic {CAUSE_CLEAR, CAUSE_DEATH} end_cause_t;
  localparam int DEF_NUM_BIKERS = 4;
  localparam int DEF_MAX_LEVEL = 9;
  localparam int DEF_LIVES = 3;
endpackage

// File: rtl/tenths_countdown.sv
// tenths_countdown: loadable 8-bit down-counter; tc flags the tick that exhausts the loaded count
module tenths_countdown (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       tick,
  output logic       tc
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? value : (tick && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
  end
  assign tc = tick && !load && cnt_q == 8'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-level FSM driving biker enables, level/lives and level pulses.
// Define LEVEL_SEQ_ENDLESS_EN to keep replaying MAX_LEVEL instead of winning.
module level_sequencer
  import game_pkg::*;
#(
  parameter int NUM_BIKERS         = DEF_NUM_BIKERS,
  parameter int COUNTDOWN_TENTHS   = 30,
  parameter int CLEAR_DELAY_TENTHS = 10,
  parameter int MAX_LEVEL          = DEF_MAX_LEVEL,
  parameter int LIVES              = DEF_LIVES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startGame,
  input  logic                  oneTensSec,
  input  logic [NUM_BIKERS-1:0] bikerHit,
  input  logic                  playerHit,
  output logic                  startOfLevel,
  output logic                  startMovement,
  output logic                  endLevel,
  output logic [NUM_BIKERS-1:0] bikerEnabled,
  output logic [3:0]            level,
  output logic [1:0]            lives,
  output logic                  gameOver,
  output logic                  gameWon
);
  level_state_t state_q, state_d;
  end_cause_t cause_q, cause_d;
  logic [NUM_BIKERS-1:0] mask_q, mask_d;
  logic [3:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic won_q, won_d;
  logic tmr_load, tc;
  logic [7:0] tmr_value;
  tenths_countdown u_timer (
    .clk(clk), .reset(reset), .load(tmr_load), .value(tmr_value), .tick(oneTensSec), .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    mask_d = mask_q;
    level_d = level_q;
    lives_d = lives_q;
    won_d = won_q;
    case (state_q)
      S_IDLE, S_GAME_OVER:
        if (startGame) begin
          state_d = S_LOAD;
          level_d = 4'd1;
          lives_d = 2'(LIVES);
          won_d = 1'b0;
        end
      S_LOAD: state_d = S_COUNTDOWN;
      S_COUNTDOWN: state_d = tc ? S_GO : S_COUNTDOWN;
      S_GO: state_d = S_PLAY;
      S_PLAY: begin
        mask_d = mask_q & ~bikerHit;
        if (playerHit) begin
          state_d = S_END;
          cause_d = CAUSE_DEATH;
        end else if (mask_d == '0) begin
          state_d = S_CLEAR_DELAY;
          cause_d = CAUSE_CLEAR;
        end
      end
      S_CLEAR_DELAY: state_d = tc ? S_END : S_CLEAR_DELAY;
      S_END:
        if (cause_q == CAUSE_DEATH) begin
          lives_d = lives_q != 2'd0 ? lives_q - 2'd1 : 2'd0;
          state_d = lives_d == 2'd0 ? S_GAME_OVER : S_LOAD;
        end else if (level_q == 4'(MAX_LEVEL)) begin
`ifdef LEVEL_SEQ_ENDLESS_EN
          state_d = S_LOAD;
`else
          state_d = S_GAME_OVER;
          won_d = 1'b1;
`endif
        end else begin
          level_d = level_q + 4'd1;
          state_d = S_LOAD;
        end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_END) mask_d = '0;
    // mask is built from the level being entered so it is valid alongside startOfLevel
    if (state_d == S_LOAD)
      for (int i = 0; i < NUM_BIKERS; i++) mask_d[i] = i < int'(level_d);
    tmr_load = state_d != state_q && (state_d == S_COUNTDOWN || state_d == S_CLEAR_DELAY);
    tmr_value = state_d == S_COUNTDOWN ? 8'(COUNTDOWN_TENTHS) : 8'(CLEAR_DELAY_TENTHS);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_CLEAR;
      mask_q <= '0;
      level_q <= 4'd1;
      lives_q <= 2'(LIVES);
      won_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      mask_q <= mask_d;
      level_q <= level_d;
      lives_q <= lives_d;
      won_q <= won_d;
    end
  end
  assign startOfLevel = state_q == S_LOAD;
  assign startMovement = state_q == S_GO;
  assign endLevel = state_q == S_END;
  assign gameOver = state_q == S_GAME_OVER;
  assign gameWon = won_q;
  assign bikerEnabled = mask_q;
  assign level = level_q;
  assign lives = lives_q;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: random game play checked against a rule-level model of levels, lives and timing
module tb_level_sequencer;
  localparam int NB = 4;
  localparam int CD = 30;
  localparam int CLR = 10;
  localparam int MAXL = 9;
  localparam int LV = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic startGame = 1'b0;
  logic oneTensSec = 1'b0;
  logic playerHit = 1'b0;
  logic [NB-1:0] bikerHit = '0;
  logic startOfLevel, startMovement, endLevel, gameOver, gameWon;
  logic [NB-1:0] bikerEnabled;
  logic [3:0] level;
  logic [1:0] lives;
  int errors = 0;
  int checks = 0;
  int exp_level, exp_lives;
  logic [NB-1:0] exp_mask;

  level_sequencer #(
    .NUM_BIKERS(NB), .COUNTDOWN_TENTHS(CD), .CLEAR_DELAY_TENTHS(CLR), .MAX_LEVEL(MAXL), .LIVES(LV)
  ) dut (
    .clk(clk), .reset(reset), .startGame(startGame), .oneTensSec(oneTensSec),
    .bikerHit(bikerHit), .playerHit(playerHit), .startOfLevel(startOfLevel),
    .startMovement(startMovement), .endLevel(endLevel), .bikerEnabled(bikerEnabled),
    .level(level), .lives(lives), .gameOver(gameOver), .gameWon(gameWon)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] fill(input int lvl);
    return NB'((1 << (lvl < NB ? lvl : NB)) - 1);
  endfunction

  function automatic logic [NB-1:0] rnd_hits();
    int r;
    r = int'($urandom_range(0, 3));
    return r == 0 ? NB'($urandom) : r == 1 ? NB'(1 << $urandom_range(0, NB - 1)) : '0;
  endfunction

  function automatic logic rnd_bit();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic logic rnd_tick();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic step(input logic tick, input logic [NB-1:0] bh, input logic ph, input logic sg);
    oneTensSec = tick;
    bikerHit = bh;
    playerHit = ph;
    startGame = sg;
    @(posedge clk);
    #1;
    oneTensSec = 1'b0;
    bikerHit = '0;
    playerHit = 1'b0;
    startGame = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sol"}, 32'(startOfLevel), 0);
    check({tag, "_move"}, 32'(startMovement), 0);
    check({tag, "_end"}, 32'(endLevel), 0);
    check({tag, "_mask"}, 32'(bikerEnabled), 0);
    check({tag, "_level"}, 32'(level), 1);
    check({tag, "_lives"}, 32'(lives), LV);
    check({tag, "_over"}, 32'(gameOver), 0);
    check({tag, "_won"}, 32'(gameWon), 0);
  endtask

  // entered while observing the startOfLevel cycle; leaves in the first PLAY cycle
  task automatic countdown_phase();
    int n = 0;
    step(1'b1, rnd_hits(), rnd_bit(), rnd_bit());
    while (n < CD) begin
      logic t;
      check("cd_mask", 32'(bikerEnabled), 32'(exp_mask));
      check("cd_move", 32'(startMovement), 0);
      t = rnd_tick();
      if (t) n++;
      step(t, rnd_hits(), rnd_bit(), rnd_bit());
    end
    check("go_move", 32'(startMovement), 1);
    check("go_level", 32'(level), exp_level);
    step(rnd_tick(), rnd_hits(), rnd_bit(), rnd_bit());
    check("play_entry_mask", 32'(bikerEnabled), 32'(exp_mask));
  endtask

  task automatic play_phase(input int pd, input bit tie, output bit died);
    logic [NB-1:0] bh;
    logic ph;
    bit first = 1'b1;
    died = 1'b0;
    forever begin
      bh = (tie && first) ? exp_mask : rnd_hits();
      ph = (tie && first) || ($urandom_range(0, 99) < pd);
      first = 1'b0;
      step(rnd_tick(), bh, ph, rnd_bit());
      if (ph) begin
        died = 1'b1;
        check("death_end", 32'(endLevel), 1);
        check("death_mask", 32'(bikerEnabled), 0);
        return;
      end
      exp_mask &= ~bh;
      check("play_end", 32'(endLevel), 0);
      check("play_mask", 32'(bikerEnabled), 32'(exp_mask));
      if (exp_mask == '0) return;
    end
  endtask

  task automatic clear_phase();
    int n = 0;
    while (n < CLR) begin
      logic t;
      check("clr_end", 32'(endLevel), 0);
      t = rnd_tick();
      if (t) n++;
      step(t, rnd_hits(), rnd_bit(), rnd_bit());
    end
    check("clr_endlevel", 32'(endLevel), 1);
    check("clr_mask", 32'(bikerEnabled), 0);
  endtask

  task automatic play_game(input int pd, input bit tie);
    bit died, go, won;
    int pde;
    step(rnd_tick(), rnd_hits(), rnd_bit(), 1'b1);
    exp_level = 1;
    exp_lives = LV;
    forever begin
      exp_mask = fill(exp_level);
      check("sol", 32'(startOfLevel), 1);
      check("sol_level", 32'(level), exp_level);
      check("sol_lives", 32'(lives), exp_lives);
      check("sol_mask", 32'(bikerEnabled), 32'(exp_mask));
      check("sol_won", 32'(gameWon), 0);
      countdown_phase();
`ifdef LEVEL_SEQ_ENDLESS_EN
      pde = exp_level == MAXL ? 50 : pd;
`else
      pde = pd;
`endif
      play_phase(pde, tie, died);
      tie = 1'b0;
      if (!died) clear_phase();
      won = 1'b0;
      if (died) begin
        exp_lives--;
        go = exp_lives == 0;
      end else if (exp_level == MAXL) begin
`ifdef LEVEL_SEQ_ENDLESS_EN
        go = 1'b0;
`else
        go = 1'b1;
        won = 1'b1;
`endif
      end else begin
        exp_level++;
        go = 1'b0;
      end
      step(rnd_tick(), rnd_hits(), rnd_bit(), 1'b0);
      check("next_sol", 32'(startOfLevel), 32'(!go));
      check("over", 32'(gameOver), 32'(go));
      check("won", 32'(gameWon), 32'(won));
      check("lives", 32'(lives), exp_lives);
      check("level", 32'(level), exp_level);
      if (go) begin
        check("over_mask", 32'(bikerEnabled), 0);
        return;
      end
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 check_reset("por");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) step(1'b1, rnd_hits(), rnd_bit(), 1'b0);
    check_reset("idle");
    play_game(0, 1'b0);
    play_game(30, 1'b1);
    play_game(60, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_pre_sol", 32'(startOfLevel), 1);
    repeat (5) step(1'b1, rnd_hits(), rnd_bit(), 1'b0);
    #2 reset = 1'b1;
    #1 check_reset("mid_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (60) begin
      step(1'b1, rnd_hits(), rnd_bit(), 1'b0);
      check("post_rst_move", 32'(startMovement), 0);
      check("post_rst_sol", 32'(startOfLevel), 0);
      check("post_rst_mask", 32'(bikerEnabled), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
